// File: rtl/phy_tx_striper.sv
// phy_tx_striper
//   Single-clock PHY transmit path. Bus words are queued in a small FIFO and
//   striped bytewise across LANES serial lanes, one bit per lane per clk,
//   MSB of each symbol first. A free-running 3-bit counter marks symbol
//   boundaries. After reset every lane sends TRAIN_SYM COM symbols. When no
//   data is queued, the lanes carry IDL fill.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-high
//   input_bus   word to transmit (BUS_W bits)
//   valid       input_bus qualifier
//   ready       FIFO can accept a word this cycle
//   tx_serial   serial bit per lane (MSB of symbol first)
//   tx_k        1 while the lane carries a control symbol (COM/IDL)
//   fifo_level  words currently held in the FIFO
//   overflow    sticky: valid was seen while ready was 0
module phy_tx_striper #(
  parameter int         BUS_W     = 32,
  parameter int         LANES     = 4,
  parameter int         DEPTH     = 4,
  parameter int         TRAIN_SYM = 4,
  parameter logic [7:0] COM       = 8'hBC,
  parameter logic [7:0] IDL       = 8'h7C
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUS_W-1:0]         input_bus,
  input  logic                     valid,
  output logic                     ready,
  output logic [LANES-1:0]         tx_serial,
  output logic [LANES-1:0]         tx_k,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int BPL    = BUS_W / (8 * LANES);
  localparam int SLOT_W = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int SYM_W  = (TRAIN_SYM > 1) ? $clog2(TRAIN_SYM) : 1;

  typedef enum logic [1:0] {
    ST_TRAIN,
    ST_IDLE,
    ST_DATA
  } state_t;

  state_t                  state, state_nxt;
  logic [2:0]              bit_cnt;
  logic [SYM_W-1:0]        sym_cnt, sym_cnt_nxt;
  logic [SLOT_W-1:0]       slot, slot_nxt, slot_inc;
  logic [LANES-1:0][7:0]   shreg, shreg_nxt;
  logic [LANES-1:0]        tx_k_nxt;
  logic [BUS_W-1:0]        hold_word;

  logic [BUS_W-1:0]        fifo_mem [DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [LVL_W-1:0]        level;
  logic [BUS_W-1:0]        head_word;

  logic                    boundary;
  logic                    go_word;
  logic                    push, pop;

  // Lane bytes for one slot: byte b of the word sits in lane b%LANES, slot
  // b/LANES, so a slot is simply a contiguous 8*LANES-bit field.
  function automatic logic [8*LANES-1:0] slot_bytes(input logic [BUS_W-1:0] w,
                                                     input logic [SLOT_W-1:0] s);
    logic [BUS_W-1:0] t;
    t = w >> (8 * LANES * int'(s));
    return t[8*LANES-1:0];
  endfunction

  assign boundary   = (bit_cnt == 3'd7);
  assign slot_inc   = slot + SLOT_W'(1);
  assign head_word  = fifo_mem[rd_ptr];
  assign ready      = (level < LVL_W'(DEPTH));
  assign push       = valid && ready;
  assign fifo_level = level;

  always_comb begin
    for (int l = 0; l < LANES; l++) tx_serial[l] = shreg[l][7];
  end

  always_comb begin
    state_nxt   = state;
    sym_cnt_nxt = sym_cnt;
    slot_nxt    = slot;
    tx_k_nxt    = tx_k;
    pop         = 1'b0;
    go_word     = 1'b0;
    for (int l = 0; l < LANES; l++) shreg_nxt[l] = {shreg[l][6:0], 1'b0};

    if (boundary) begin
      unique case (state)
        ST_TRAIN: begin
          // The COM loaded at reset counts as the first training symbol.
          if (sym_cnt < SYM_W'(TRAIN_SYM - 1)) begin
            sym_cnt_nxt = sym_cnt + SYM_W'(1);
            shreg_nxt   = {LANES{COM}};
          end else begin
            go_word = 1'b1;
          end
        end
        ST_DATA: begin
          if (slot != SLOT_W'(BPL - 1)) begin
            slot_nxt  = slot_inc;
            shreg_nxt = slot_bytes(hold_word, slot_inc);
          end else begin
            go_word = 1'b1;
          end
        end
        default: go_word = 1'b1;
      endcase

      // Start the next word straight away if one is queued, else fill with IDL.
      if (go_word) begin
        slot_nxt = '0;
        if (level != '0) begin
          pop       = 1'b1;
          shreg_nxt = slot_bytes(head_word, '0);
          tx_k_nxt  = '0;
          state_nxt = ST_DATA;
        end else begin
          shreg_nxt = {LANES{IDL}};
          tx_k_nxt  = '1;
          state_nxt = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_TRAIN;
      bit_cnt  <= '0;
      sym_cnt  <= '0;
      slot     <= '0;
      shreg    <= {LANES{COM}};
      tx_k     <= '1;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt + 3'd1;
      sym_cnt  <= sym_cnt_nxt;
      slot     <= slot_nxt;
      shreg    <= shreg_nxt;
      tx_k     <= tx_k_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (valid && !ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= input_bus;
    if (pop)  hold_word <= head_word;
  end

endmodule

// File: tb/tb_phy_tx_striper.sv
// Directed bench for phy_tx_striper: a 4-lane instance (BPL=1) and a 2-lane
// instance (BPL=2). Inputs change on the falling edge, outputs are sampled
// on the falling edge; cycle 0 is the first cycle after reset release.
module tb_phy_tx_striper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, valid_a, ready_a, ovf_a;
  logic [31:0] bus_a;
  logic [3:0]  txs_a, txk_a;
  logic [2:0]  lvl_a;

  logic        reset_b, valid_b, ready_b, ovf_b;
  logic [31:0] bus_b;
  logic [1:0]  txs_b, txk_b;
  logic [2:0]  lvl_b;

  int checks   = 0;
  int failures = 0;

  phy_tx_striper #(.BUS_W(32), .LANES(4), .DEPTH(4), .TRAIN_SYM(4)) dut_a (
    .clk(clk), .reset(reset_a), .input_bus(bus_a), .valid(valid_a),
    .ready(ready_a), .tx_serial(txs_a), .tx_k(txk_a),
    .fifo_level(lvl_a), .overflow(ovf_a)
  );

  phy_tx_striper #(.BUS_W(32), .LANES(2), .DEPTH(4), .TRAIN_SYM(4)) dut_b (
    .clk(clk), .reset(reset_b), .input_bus(bus_b), .valid(valid_b),
    .ready(ready_b), .tx_serial(txs_b), .tx_k(txk_b),
    .fifo_level(lvl_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Checks one 8-cycle symbol: lane l carries bytes[8l+7:8l], MSB first.
  task automatic run_sym(input string tag, input bit use_b,
                         input logic [31:0] bytes, input logic [3:0] k);
    int nl = use_b ? 2 : 4;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] exp_s, obs_s, obs_k;
      @(negedge clk);
      exp_s = '0;
      for (int l = 0; l < nl; l++) exp_s[l] = bytes[8*l + 7 - i];
      obs_s = use_b ? {2'b00, txs_b} : txs_a;
      obs_k = use_b ? {2'b00, txk_b} : txk_a;
      check($sformatf("%s_ser%0d", tag, i), 32'(obs_s), 32'(exp_s));
      check($sformatf("%s_k%0d", tag, i), 32'(obs_k), 32'(k));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] w [6];
    logic [31:0] v [4];
    w[0] = 32'h03020100; w[1] = 32'h13121110; w[2] = 32'h23222120;
    w[3] = 32'h33323130; w[4] = 32'h43424140; w[5] = 32'h53525150;
    v[0] = 32'h0F0E0D0C; v[1] = 32'h1F1E1D1C; v[2] = 32'h2F2E2D2C; v[3] = 32'h3F3E3D3C;

    reset_a = 1'b1; valid_a = 1'b0; bus_a = '0;
    reset_b = 1'b1; valid_b = 1'b0; bus_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_a",   32'(txs_a),   32'hF);
    check("rst_k_a",     32'(txk_a),   32'hF);
    check("rst_ready_a", 32'(ready_a), 32'h1);
    check("rst_level_a", 32'(lvl_a),   32'h0);
    check("rst_ovf_a",   32'(ovf_a),   32'h0);
    check("rst_ser_b",   32'(txs_b),   32'h3);
    check("rst_k_b",     32'(txk_b),   32'h3);
    check("rst_ready_b", 32'(ready_b), 32'h1);
    check("rst_level_b", 32'(lvl_b),   32'h0);
    check("rst_ovf_b",   32'(ovf_b),   32'h0);

    @(posedge clk); #1 reset_a = 1'b0;

    // Training, then one word pushed at cycle 5, then idle fill.
    fork
      begin
        repeat (4) run_sym("train", 1'b0, 32'hBCBCBCBC, 4'hF);
        run_sym("word1", 1'b0, 32'hA1B2C3D4, 4'h0);
        run_sym("idle1", 1'b0, 32'h7C7C7C7C, 4'hF);
      end
      begin
        repeat (6) @(negedge clk);
        valid_a = 1'b1; bus_a = 32'hA1B2C3D4;
        @(negedge clk);
        valid_a = 1'b0;
        check("lvl_after_push", 32'(lvl_a), 32'h1);
        repeat (26) @(negedge clk);
        check("lvl_after_pop", 32'(lvl_a), 32'h0);
        check("ready_after_pop", 32'(ready_a), 32'h1);
      end
    join

    // Six words honouring ready: back-to-back output, no overflow.
    fork
      begin
        run_sym("idle2", 1'b0, 32'h7C7C7C7C, 4'hF);
        for (int i = 0; i < 6; i++) run_sym($sformatf("b2b%0d", i), 1'b0, w[i], 4'h0);
        run_sym("idle3", 1'b0, 32'h7C7C7C7C, 4'hF);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          int waited = 0;
          @(negedge clk);
          if (i == 4) begin
            check("full_ready", 32'(ready_a), 32'h0);
            check("full_level", 32'(lvl_a),   32'h4);
          end
          while (!ready_a && waited < 40) begin
            valid_a = 1'b0;
            waited++;
            @(negedge clk);
          end
          if (!ready_a) check("ready_wait", 32'(ready_a), 32'h1);
          valid_a = 1'b1; bus_a = w[i];
        end
        @(negedge clk);
        valid_a = 1'b0;
        check("b2b_ovf", 32'(ovf_a), 32'h0);
      end
    join

    // Fill the FIFO, then push once while full: sticky overflow, word dropped.
    fork
      begin
        run_sym("idle4", 1'b0, 32'h7C7C7C7C, 4'hF);
        for (int i = 0; i < 4; i++) run_sym($sformatf("ovw%0d", i), 1'b0, v[i], 4'h0);
        run_sym("idle5", 1'b0, 32'h7C7C7C7C, 4'hF);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          valid_a = 1'b1; bus_a = v[i];
        end
        @(negedge clk);
        check("pre_ovf_ready", 32'(ready_a), 32'h0);
        check("pre_ovf_flag",  32'(ovf_a),   32'h0);
        valid_a = 1'b1; bus_a = 32'hDEADBEEF;
        @(negedge clk);
        valid_a = 1'b0;
        check("ovf_set",   32'(ovf_a), 32'h1);
        check("ovf_level", 32'(lvl_a), 32'h4);
        repeat (30) @(negedge clk);
        check("ovf_sticky", 32'(ovf_a), 32'h1);
      end
    join

    // Reset in the middle of a data symbol with two words still queued.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_a = 1'b1; bus_a = 32'h55AA33CC + 32'(i);
    end
    @(negedge clk);
    valid_a = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_k",     32'(txk_a), 32'h0);
    check("mid_level", 32'(lvl_a), 32'h2);
    reset_a = 1'b1;
    #1;
    check("mrst_ser",   32'(txs_a),   32'hF);
    check("mrst_k",     32'(txk_a),   32'hF);
    check("mrst_level", 32'(lvl_a),   32'h0);
    check("mrst_ready", 32'(ready_a), 32'h1);
    check("mrst_ovf",   32'(ovf_a),   32'h0);
    @(posedge clk); #1 reset_a = 1'b0;
    repeat (4) run_sym("retrain", 1'b0, 32'hBCBCBCBC, 4'hF);
    run_sym("post_idle0", 1'b0, 32'h7C7C7C7C, 4'hF);
    run_sym("post_idle1", 1'b0, 32'h7C7C7C7C, 4'hF);

    // Two-lane instance: two slots per lane per word.
    @(posedge clk); #1 reset_b = 1'b0;
    fork
      begin
        repeat (4) run_sym("b_train", 1'b1, 32'h0000BCBC, 4'h3);
        run_sym("b_slot0", 1'b1, 32'h00003344, 4'h0);
        run_sym("b_slot1", 1'b1, 32'h00001122, 4'h0);
        run_sym("b_idle",  1'b1, 32'h00007C7C, 4'h3);
      end
      begin
        repeat (6) @(negedge clk);
        valid_b = 1'b1; bus_b = 32'h11223344;
        @(negedge clk);
        valid_b = 1'b0;
        check("b_lvl", 32'(lvl_b), 32'h1);
      end
    join
    check("b_ready", 32'(ready_b), 32'h1);
    check("b_ovf",   32'(ovf_b),   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
